// File: rtl/flash_prog_pkg.sv
// Shared types and constants for the flash_prog NOR flash program/erase block.
// Command bytes follow the JEDEC AMD-style command set in byte mode.
package flash_prog_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_WR_GAP,
        ST_POLL_RD,
        ST_POLL_GAP,
        ST_POLL_EVAL,
        ST_RST_CMD,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_PROG  = 1'b0,
        OP_ERASE = 1'b1
    } op_t;

    // Address source for a sequence-ROM bus write
    typedef enum logic [1:0] {
        ASEL_U1,
        ASEL_U2,
        ASEL_CMD,
        ASEL_ZERO
    } asel_t;

    localparam int SEQ_IDX_W = 3;

    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_55 = 8'h55;
    localparam logic [7:0] CMD_A0 = 8'hA0;
    localparam logic [7:0] CMD_80 = 8'h80;
    localparam logic [7:0] CMD_30 = 8'h30;
    localparam logic [7:0] CMD_F0 = 8'hF0;

    // Value DQ7 shows once the embedded algorithm has finished
    function automatic logic expected_dq7(input op_t op, input logic [7:0] data);
        return (op == OP_ERASE) ? 1'b1 : data[7];
    endfunction

endpackage

// File: rtl/flash_prog_seq.sv
// Combinational sequence ROM: (op, index) -> bus-write address select, data byte, last flag.
module flash_prog_seq
    import flash_prog_pkg::*;
(
    input  op_t                  op,
    input  logic [SEQ_IDX_W-1:0] idx,
    input  logic [7:0]           prog_data,
    output asel_t                addr_sel,
    output logic [7:0]           data,
    output logic                 last
);

    always_comb begin
        addr_sel = ASEL_ZERO;
        data     = CMD_F0;
        last     = 1'b1;
        if (op == OP_PROG) begin
            case (idx)
                3'd0: begin addr_sel = ASEL_U1;  data = CMD_AA;    last = 1'b0; end
                3'd1: begin addr_sel = ASEL_U2;  data = CMD_55;    last = 1'b0; end
                3'd2: begin addr_sel = ASEL_U1;  data = CMD_A0;    last = 1'b0; end
                3'd3: begin addr_sel = ASEL_CMD; data = prog_data; last = 1'b1; end
                default: ;
            endcase
        end else begin
            case (idx)
                3'd0: begin addr_sel = ASEL_U1;  data = CMD_AA; last = 1'b0; end
                3'd1: begin addr_sel = ASEL_U2;  data = CMD_55; last = 1'b0; end
                3'd2: begin addr_sel = ASEL_U1;  data = CMD_80; last = 1'b0; end
                3'd3: begin addr_sel = ASEL_U1;  data = CMD_AA; last = 1'b0; end
                3'd4: begin addr_sel = ASEL_U2;  data = CMD_55; last = 1'b0; end
                3'd5: begin addr_sel = ASEL_CMD; data = CMD_30; last = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/flash_prog.sv
// flash_prog: issues JEDEC byte-program / sector-erase bus cycles and polls for completion.
// Optional: define FLASH_PROG_TOGGLE_EN to use DQ6 toggle-bit polling instead of DQ7 data#-polling.
module flash_prog
    import flash_prog_pkg::*;
#(
    parameter int          WE_CYC  = 3,
    parameter int          RD_CYC  = 3,
    parameter logic [23:0] TMO_CYC = 24'd6000000,
    parameter logic [21:0] ADDR_U1 = 22'hAAA,
    parameter logic [21:0] ADDR_U2 = 22'h555
) (
    input  logic        zclk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [21:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [21:0] flash_a,
    output logic [7:0]  flash_dq,
    output logic        flash_dq_oe,
    input  logic [7:0]  flash_d,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n
);

    localparam logic [7:0] WE_LAST = 8'(WE_CYC - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_CYC - 1);

    state_t               state_reg, state_next;
    op_t                  op_reg, op_next;
    logic [21:0]          addr_reg, addr_next;
    logic [7:0]           data_reg, data_next;
    logic [SEQ_IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic [23:0]          tmo_reg, tmo_next;
    logic                 dq5_seen_reg, dq5_seen_next;
    logic                 rst_cmd_reg, rst_cmd_next;
    logic                 err_reg, err_next;
    logic [7:0]           poll_a_reg, poll_a_next;
`ifdef FLASH_PROG_TOGGLE_EN
    logic [7:0]           poll_b_reg, poll_b_next;
    logic                 phase_reg, phase_next;
`endif

    asel_t       seq_addr_sel;
    logic [7:0]  seq_data;
    logic        seq_last;
    logic [21:0] wr_addr;
    logic [7:0]  wr_data;
    logic        tmo_hit;
    logic        poll_ok;
    logic        poll_dq5;
    logic        unused_poll;

    flash_prog_seq u_seq (
        .op        (op_reg),
        .idx       (idx_reg),
        .prog_data (data_reg),
        .addr_sel  (seq_addr_sel),
        .data      (seq_data),
        .last      (seq_last)
    );

    // The reset-command write overrides whatever the sequence ROM points at
    always_comb begin
        wr_data = rst_cmd_reg ? CMD_F0 : seq_data;
        wr_addr = 22'd0;
        if (!rst_cmd_reg) begin
            case (seq_addr_sel)
                ASEL_U1:  wr_addr = ADDR_U1;
                ASEL_U2:  wr_addr = ADDR_U2;
                ASEL_CMD: wr_addr = addr_reg;
                default:  wr_addr = 22'd0;
            endcase
        end
    end

    assign tmo_hit = (tmo_reg >= TMO_CYC);

`ifdef FLASH_PROG_TOGGLE_EN
    assign poll_ok     = (poll_a_reg[6] == poll_b_reg[6]);
    assign poll_dq5    = poll_b_reg[5];
    assign unused_poll = ^{poll_a_reg[7], poll_a_reg[5:0], poll_b_reg[7], poll_b_reg[4:0]};
`else
    assign poll_ok     = (poll_a_reg[7] == expected_dq7(op_reg, data_reg));
    assign poll_dq5    = poll_a_reg[5];
    assign unused_poll = ^{poll_a_reg[6], poll_a_reg[4:0]};
`endif

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        tmo_next      = tmo_reg;
        dq5_seen_next = dq5_seen_reg;
        rst_cmd_next  = rst_cmd_reg;
        err_next      = err_reg;
        poll_a_next   = poll_a_reg;
`ifdef FLASH_PROG_TOGGLE_EN
        poll_b_next   = poll_b_reg;
        phase_next    = phase_reg;
`endif

        // Timeout runs across every poll state and saturates once reached
        if ((state_reg == ST_POLL_RD || state_reg == ST_POLL_GAP ||
             state_reg == ST_POLL_EVAL) && !tmo_hit) begin
            tmo_next = tmo_reg + 24'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_next       = op_t'(cmd_op);
                    addr_next     = cmd_addr;
                    data_next     = cmd_data;
                    idx_next      = '0;
                    cnt_next      = 8'd0;
                    dq5_seen_next = 1'b0;
                    rst_cmd_next  = 1'b0;
                    err_next      = 1'b0;
`ifdef FLASH_PROG_TOGGLE_EN
                    phase_next    = 1'b0;
`endif
                    state_next    = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                cnt_next   = 8'd0;
                state_next = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_reg == WE_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = ST_WR_HOLD;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_WR_HOLD: state_next = ST_WR_GAP;
            ST_WR_GAP: begin
                if (rst_cmd_reg) begin
                    state_next = ST_DONE;
                end else if (seq_last) begin
                    tmo_next   = 24'd0;
                    cnt_next   = 8'd0;
                    state_next = ST_POLL_RD;
                end else begin
                    idx_next   = idx_reg + 3'd1;
                    state_next = ST_WR_SETUP;
                end
            end
            ST_POLL_RD: begin
                if (cnt_reg == RD_LAST) begin
                    cnt_next = 8'd0;
`ifdef FLASH_PROG_TOGGLE_EN
                    if (phase_reg) poll_b_next = flash_d;
                    else           poll_a_next = flash_d;
`else
                    poll_a_next = flash_d;
`endif
                    state_next = ST_POLL_GAP;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_POLL_GAP: begin
`ifdef FLASH_PROG_TOGGLE_EN
                // Toggle polling needs a pair of reads before each decision
                if (!phase_reg) begin
                    phase_next = 1'b1;
                    state_next = ST_POLL_RD;
                end else begin
                    phase_next = 1'b0;
                    state_next = ST_POLL_EVAL;
                end
`else
                state_next = ST_POLL_EVAL;
`endif
            end
            ST_POLL_EVAL: begin
                // A completed poll wins even if the timeout has just expired
                if (poll_ok) begin
                    err_next   = 1'b0;
                    state_next = ST_DONE;
                end else if (tmo_hit || dq5_seen_reg) begin
                    state_next = ST_RST_CMD;
                end else begin
                    if (poll_dq5) dq5_seen_next = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = ST_POLL_RD;
                end
            end
            ST_RST_CMD: begin
                rst_cmd_next = 1'b1;
                err_next     = 1'b1;
                cnt_next     = 8'd0;
                state_next   = ST_WR_SETUP;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge zclk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_PROG;
            addr_reg     <= 22'd0;
            data_reg     <= 8'd0;
            idx_reg      <= '0;
            cnt_reg      <= 8'd0;
            tmo_reg      <= 24'd0;
            dq5_seen_reg <= 1'b0;
            rst_cmd_reg  <= 1'b0;
            err_reg      <= 1'b0;
            poll_a_reg   <= 8'd0;
`ifdef FLASH_PROG_TOGGLE_EN
            poll_b_reg   <= 8'd0;
            phase_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            tmo_reg      <= tmo_next;
            dq5_seen_reg <= dq5_seen_next;
            rst_cmd_reg  <= rst_cmd_next;
            err_reg      <= err_next;
            poll_a_reg   <= poll_a_next;
`ifdef FLASH_PROG_TOGGLE_EN
            poll_b_reg   <= poll_b_next;
            phase_reg    <= phase_next;
`endif
        end
    end

    // Pin and status outputs are decoded purely from the registered state
    always_comb begin
        cmd_ready   = (state_reg == ST_IDLE);
        busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
        done        = (state_reg == ST_DONE);
        err         = (state_reg == ST_DONE) && err_reg;
        flash_a     = 22'd0;
        flash_dq    = 8'd0;
        flash_dq_oe = 1'b0;
        flash_ce_n  = 1'b1;
        flash_oe_n  = 1'b1;
        flash_we_n  = 1'b1;
        case (state_reg)
            ST_WR_SETUP, ST_WR_HOLD: begin
                flash_a     = wr_addr;
                flash_dq    = wr_data;
                flash_dq_oe = 1'b1;
                flash_ce_n  = 1'b0;
            end
            ST_WR_PULSE: begin
                flash_a     = wr_addr;
                flash_dq    = wr_data;
                flash_dq_oe = 1'b1;
                flash_ce_n  = 1'b0;
                flash_we_n  = 1'b0;
            end
            ST_WR_GAP: begin
                flash_a  = wr_addr;
                flash_dq = wr_data;
            end
            ST_POLL_RD: begin
                flash_a    = addr_reg;
                flash_ce_n = 1'b0;
                flash_oe_n = 1'b0;
            end
            ST_POLL_GAP, ST_POLL_EVAL: flash_a = addr_reg;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_prog.sv
// Self-checking bench for flash_prog: behavioural flash model, directed vector table,
// multi-cycle corner sequences and randomized commands against a reference model.
module tb_flash_prog;

    localparam int          WE_CYC  = 3;
    localparam int          RD_CYC  = 3;
    localparam logic [23:0] TMO_CYC = 24'd100;

    logic        zclk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [21:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [21:0] flash_a;
    logic [7:0]  flash_dq;
    logic        flash_dq_oe;
    logic [7:0]  flash_d = 8'h00;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;

    flash_prog #(
        .WE_CYC  (WE_CYC),
        .RD_CYC  (RD_CYC),
        .TMO_CYC (TMO_CYC),
        .ADDR_U1 (22'hAAA),
        .ADDR_U2 (22'h555)
    ) dut (
        .zclk        (zclk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .flash_a     (flash_a),
        .flash_dq    (flash_dq),
        .flash_dq_oe (flash_dq_oe),
        .flash_d     (flash_d),
        .flash_ce_n  (flash_ce_n),
        .flash_oe_n  (flash_oe_n),
        .flash_we_n  (flash_we_n)
    );

    always #5 zclk = ~zclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Flash model: the first busy_polls reads return busy_val, later reads done_val
    int         busy_polls = 0;
    logic [7:0] busy_val   = 8'h00;
    logic [7:0] done_val   = 8'h00;
    int         poll_base  = 0;
    int         poll_cnt   = 0;
    logic       prev_oe_n  = 1'b1;

    typedef struct {
        logic [21:0] a;
        logic [7:0]  d;
        int          len;
        bit          ok;
    } wr_t;

    wr_t wr_q[$];
    wr_t cur;
    int  we_len = 0;

    function automatic logic [7:0] resp(input int k);
        return (k <= busy_polls) ? busy_val : done_val;
    endfunction

    always @(negedge zclk) begin
        if (!flash_oe_n && prev_oe_n) begin
            poll_cnt = poll_cnt + 1;
            flash_d  = resp(poll_cnt - poll_base);
        end
        prev_oe_n = flash_oe_n;
        if (!flash_we_n) begin
            if (we_len == 0) begin
                cur.a  = flash_a;
                cur.d  = flash_dq;
                cur.ok = 1'b1;
            end
            if (flash_ce_n || !flash_dq_oe || !flash_oe_n) cur.ok = 1'b0;
            we_len = we_len + 1;
        end else if (we_len != 0) begin
            cur.len = we_len;
            wr_q.push_back(cur);
            we_len = 0;
        end
    end

    logic [21:0] exp_a[8];
    logic [7:0]  exp_d[8];
    int          exp_n;

    task automatic push_exp(input logic [21:0] a, input logic [7:0] d);
        exp_a[exp_n] = a;
        exp_d[exp_n] = d;
        exp_n++;
    endtask

    // JEDEC command sequence as the flash datasheet lists it
    task automatic build_exp(input bit op, input logic [21:0] a, input logic [7:0] d, input bit e);
        exp_n = 0;
        push_exp(22'hAAA, 8'hAA);
        push_exp(22'h555, 8'h55);
        if (!op) begin
            push_exp(22'hAAA, 8'hA0);
            push_exp(a, d);
        end else begin
            push_exp(22'hAAA, 8'h80);
            push_exp(22'hAAA, 8'hAA);
            push_exp(22'h555, 8'h55);
            push_exp(a, 8'h30);
        end
        if (e) push_exp(22'h000000, 8'hF0);
    endtask

    // Reference outcome: walk the model's read values in time order
    task automatic ref_poll(input bit op, input logic [7:0] d, output int polls, output bit e);
        bit         want7;
        bit         dq5_seen;
        logic [7:0] v;
        int         elapsed;
        want7    = op ? 1'b1 : d[7];
        dq5_seen = 1'b0;
        polls    = 0;
        e        = 1'b1;
        for (int k = 1; k < 10000; k++) begin
            v       = resp(k);
            elapsed = (RD_CYC + 2) * k - 1;
            polls   = k;
            if (v[7] == want7) begin e = 1'b0; break; end
            if (elapsed >= int'(TMO_CYC) || dq5_seen) begin e = 1'b1; break; end
            if (v[5]) dq5_seen = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (cmd_ready) break;
            @(negedge zclk);
        end
        if (i == 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.ready: cmd_ready stayed 0, expected 1", name);
        end
    endtask

    task automatic wait_done(input string name, output logic e);
        int   i;
        logic pb;
        pb = busy;
        e  = 1'bx;
        for (i = 0; i < 2000; i++) begin
            @(negedge zclk);
            if (done) break;
            pb = busy;
        end
        if (i == 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.done: no done pulse within 2000 cycles, expected one", name);
        end else begin
            chk($sformatf("%s.busy_at_done", name), 32'(busy), 32'd0);
            chk($sformatf("%s.busy_before_done", name), 32'(pb), 32'd1);
            e = err;
        end
    endtask

    task automatic check_cmd(input string name, input bit op, input logic [21:0] a, input logic [7:0] d,
                             input int wr_base, input int exp_polls, input bit exp_err, input logic got_err);
        build_exp(op, a, d, exp_err);
        chk($sformatf("%s.err", name), 32'(got_err), 32'(exp_err));
        chk($sformatf("%s.nwrites", name), 32'(wr_q.size() - wr_base), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (wr_base + i < wr_q.size()) begin
                chk($sformatf("%s.w%0d.addr", name, i), 32'(wr_q[wr_base+i].a), 32'(exp_a[i]));
                chk($sformatf("%s.w%0d.data", name, i), 32'(wr_q[wr_base+i].d), 32'(exp_d[i]));
                chk($sformatf("%s.w%0d.we_len", name, i), 32'(wr_q[wr_base+i].len), 32'(WE_CYC));
                chk($sformatf("%s.w%0d.strobes", name, i), 32'(wr_q[wr_base+i].ok), 32'd1);
            end
        end
        chk($sformatf("%s.polls", name), 32'(poll_cnt - poll_base), 32'(exp_polls));
    endtask

    task automatic run_cmd(input string name, input bit op, input logic [21:0] a, input logic [7:0] d,
                           input int bp, input logic [7:0] bv, input logic [7:0] dv,
                           input int exp_polls, input bit exp_err);
        int   wr_base;
        logic got_err;
        busy_polls = bp;
        busy_val   = bv;
        done_val   = dv;
        wait_ready(name);
        wr_base   = wr_q.size();
        poll_base = poll_cnt;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        @(negedge zclk);
        cmd_valid = 1'b0;
        chk($sformatf("%s.busy_after_accept", name), 32'(busy), 32'd1);
        wait_done(name, got_err);
        check_cmd(name, op, a, d, wr_base, exp_polls, exp_err, got_err);
        @(negedge zclk);
        chk($sformatf("%s.done_one_cycle", name), 32'(done), 32'd0);
        $display("cmd %s op=%0d addr=%06h data=%02h polls=%0d err=%0d", name, op, a, d,
                 poll_cnt - poll_base, got_err);
    endtask

    typedef struct {
        bit          op;
        logic [21:0] a;
        logic [7:0]  d;
        int          bp;
        logic [7:0]  bv;
        logic [7:0]  dv;
        int          polls;
        bit          e;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          wr_base;
        int          accepts;
        int          i;
        logic        got_err;
        bit          rop;
        logic [21:0] ra;
        logic [7:0]  rd;
        int          rbp;
        logic [7:0]  rbv;
        logic [7:0]  rdv;
        int          rpolls;
        bit          re;

        vecs[0] = '{1'b0, 22'h012345, 8'hA5, 10,   8'h00, 8'hA5, 11, 1'b0};
        vecs[1] = '{1'b1, 22'h010000, 8'h00, 1,    8'h00, 8'hFF, 2,  1'b0};
        vecs[2] = '{1'b0, 22'h000080, 8'h80, 9999, 8'h20, 8'h80, 2,  1'b1};
        vecs[3] = '{1'b0, 22'h000155, 8'h80, 9999, 8'h00, 8'h80, 21, 1'b1};
        vecs[4] = '{1'b1, 22'h3FFFFF, 8'h00, 0,    8'h00, 8'hFF, 1,  1'b0};
        vecs[5] = '{1'b0, 22'h000000, 8'h7F, 3,    8'h80, 8'h7F, 4,  1'b0};
        vecs[6] = '{1'b0, 22'h2AAAAA, 8'hA5, 1,    8'h20, 8'hA5, 2,  1'b0};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_addr  = 22'd0;
        cmd_data  = 8'd0;
        repeat (3) @(negedge zclk);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'd7);
        chk("reset.dq_oe", 32'(flash_dq_oe), 32'd0);
        chk("reset.a", 32'(flash_a), 32'd0);
        chk("reset.dq", 32'(flash_dq), 32'd0);
        rst = 1'b0;
        @(negedge zclk);

        for (int v = 0; v < 7; v++) begin
            run_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].a, vecs[v].d, vecs[v].bp,
                    vecs[v].bv, vecs[v].dv, vecs[v].polls, vecs[v].e);
        end

        // Reset during the third unlock write, then a clean command
        busy_polls = 0;
        done_val   = 8'h3C;
        wait_ready("rstmid");
        wr_base   = wr_q.size();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = 22'h001234;
        cmd_data  = 8'h3C;
        @(negedge zclk);
        cmd_valid = 1'b0;
        for (i = 0; i < 200; i++) begin
            @(negedge zclk);
            if (wr_q.size() == wr_base + 2 && !flash_we_n) break;
        end
        chk("rstmid.reached_w2", 32'(i < 200), 32'd1);
        rst = 1'b1;
        @(negedge zclk);
        chk("rstmid.strobes", 32'({flash_ce_n, flash_oe_n, flash_we_n}), 32'd7);
        chk("rstmid.dq_oe", 32'(flash_dq_oe), 32'd0);
        chk("rstmid.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge zclk);
        $display("cmd rstmid reset applied during third unlock write");
        run_cmd("after_rst", 1'b0, 22'h001234, 8'h3C, 2, 8'hC3, 8'h3C, 3, 1'b0);

        // cmd_valid held high across a whole operation
        busy_polls = 2;
        busy_val   = 8'h00;
        done_val   = 8'h91;
        wait_ready("hold");
        wr_base   = wr_q.size();
        poll_base = poll_cnt;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = 22'h00ABCD;
        cmd_data  = 8'h91;
        accepts   = 0;
        for (i = 0; i < 2000; i++) begin
            if (cmd_valid && cmd_ready) accepts++;
            @(negedge zclk);
            if (done) break;
        end
        chk("hold.done_seen", 32'(i < 2000), 32'd1);
        got_err = err;
        chk("hold.accepts", 32'(accepts), 32'd1);
        chk("hold.ready_in_done", 32'(cmd_ready), 32'd0);
        check_cmd("hold", 1'b0, 22'h00ABCD, 8'h91, wr_base, 3, 1'b0, got_err);
        $display("cmd hold op=0 addr=00abcd data=91 accepts=%0d err=%0d", accepts, got_err);
        cmd_op     = 1'b1;
        cmd_addr   = 22'h020000;
        busy_polls = 0;
        done_val   = 8'hFF;
        wr_base    = wr_q.size();
        poll_base  = poll_cnt;
        @(negedge zclk);
        chk("hold2.ready_after_done", 32'(cmd_ready), 32'd1);
        @(negedge zclk);
        cmd_valid = 1'b0;
        chk("hold2.busy_start", 32'(busy), 32'd1);
        chk("hold2.ce_start", 32'(flash_ce_n), 32'd0);
        wait_done("hold2", got_err);
        check_cmd("hold2", 1'b1, 22'h020000, 8'h91, wr_base, 1, 1'b0, got_err);
        @(negedge zclk);
        $display("cmd hold2 op=1 addr=020000 err=%0d", got_err);

        // Randomized commands against the reference model
        for (int r = 0; r < 25; r++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = 22'($urandom);
            rd  = 8'($urandom);
            rbp = ($urandom_range(0, 7) == 0) ? 9999 : int'($urandom_range(0, 8));
            rbv = 8'($urandom);
            rdv = rop ? 8'hFF : rd;
            busy_polls = rbp;
            busy_val   = rbv;
            done_val   = rdv;
            ref_poll(rop, rd, rpolls, re);
            run_cmd($sformatf("rnd%0d", r), rop, ra, rd, rbp, rbv, rdv, rpolls, re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
